// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the round-robin FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH     = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after start, modulo NUM_REQ
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    int idx;

    // Scan from the far end backwards so the candidate closest to start is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
// Optional per-requester accepted-word counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [IDX_W-1:0]   owner_next;
    logic [IDX_W-1:0]   win_next;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_winner;
    logic [NUM_REQ-1:0] gnt_raw;

    assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    assign win_next   = (pick_winner == LAST_IDX) ? '0 : pick_winner + IDX_W'(1);

    // A releasing owner hands over in the same cycle, scanning from the slot after it.
    assign pick_start = (state_q == BURST) ? owner_next : rr_ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_raw     = '0;
        if (!fifo_full) begin
            if ((state_q == BURST) && req[owner_q]) begin
                gnt_raw[owner_q] = 1'b1;
                burst_cnt_d      = burst_cnt_q + CNT_W'(1);
                if (burst_cnt_q + CNT_W'(1) == BURST_LAST) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_next;
                end
            end else if (pick_found) begin
                gnt_raw[pick_winner] = 1'b1;
                owner_d              = pick_winner;
                burst_cnt_d          = CNT_W'(1);
                if (MAX_BURST > 1) begin
                    state_d = BURST;
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = win_next;
                end
            end else if (state_q == BURST) begin
                state_d  = IDLE;
                rr_ptr_d = owner_next;
            end
        end
    end

    // Grant is combinational from req, so it must be forced low while reset is held.
    assign gnt      = rst ? gnt_raw : '0;
    assign fifo_wen = |gnt;
    assign busy     = (state_q == BURST);

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_din = fifo_din | din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stat_q, stat_d;

    // Clear wins over a same-cycle grant; counts saturate rather than wrap.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (gnt[i] && req[i] && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a 512-deep FIFO occupancy model
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wen;
    logic [15:0] fifo_din;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_cnt;
`endif

    logic       full_force, rd, ext_wr, clr, sb_en;
    int         fifo_cnt;
    logic [7:0] sent [4];
    logic [7:0] exp_sent [4];
    logic [3:0] acc_n;
    logic       wen_n;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] data;
    } exp_t;
    exp_t sbq [$];

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;
    vec_t tbl [20];

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (16),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_din  (fifo_din),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_full = full_force || (fifo_cnt >= 512);

    always_comb begin
        din = '0;
        for (int i = 0; i < 4; i++) begin
            din[i*16 +: 16] = {8'(i), sent[i]};
        end
    end

    always @(negedge clk) begin
        acc_n <= gnt & req;
        wen_n <= fifo_wen;
    end

    // Source and FIFO model: each requester advances its word on acceptance.
    always @(posedge clk) begin
        if (clr) begin
            fifo_cnt <= 0;
            for (int i = 0; i < 4; i++) sent[i] <= 8'd0;
        end else begin
            fifo_cnt <= fifo_cnt + ((wen_n || ext_wr) ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
            for (int i = 0; i < 4; i++) begin
                if (acc_n[i]) sent[i] <= sent[i] + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            total++;
            if ((gnt & ~req) != 4'd0) begin
                bad++;
                $display("FAIL gnt_without_req gnt=%b req=%b", gnt, req);
            end
            total++;
            if (fifo_full && fifo_wen) begin
                bad++;
                $display("FAIL write_while_full fifo_wen=%b required=0", fifo_wen);
            end
            total++;
            if (fifo_wen !== (|gnt)) begin
                bad++;
                $display("FAIL wen_vs_gnt fifo_wen=%b gnt=%b", fifo_wen, gnt);
            end
            if (fifo_wen && sb_en) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected gnt=%b data=%h required=none", gnt, fifo_din);
                end else begin
                    e = sbq.pop_front();
                    if (fifo_din !== e.data || gnt !== e.gnt) begin
                        bad++;
                        $display("FAIL sb_word gnt=%b data=%h required gnt=%b data=%h",
                                 gnt, fifo_din, e.gnt, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic ff, input logic rdv,
                        input logic [3:0] eg, input logic eb, input string nm);
        int id;
        req        = r;
        full_force = ff;
        rd         = rdv;
        if (eg != 4'd0) begin
            id = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) id = i;
            sbq.push_back('{eg, {8'(id), exp_sent[id]}});
            exp_sent[id] = exp_sent[id] + 8'd1;
        end
        @(negedge clk);
        chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
        chk({nm, "_busy"}, 32'(busy), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        clr        = 1'b1;
        req        = 4'd0;
        full_force = 1'b0;
        rd         = 1'b0;
        ext_wr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 4; i++) exp_sent[i] = 8'd0;
        sbq.delete();
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 1'b0, 4'b1000, 1'b0};
        tbl[1]  = '{4'b1001, 1'b0, 4'b1000, 1'b1};
        tbl[2]  = '{4'b1001, 1'b0, 4'b1000, 1'b1};
        tbl[3]  = '{4'b1001, 1'b0, 4'b1000, 1'b1};
        tbl[4]  = '{4'b1001, 1'b0, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0101, 1'b0, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[9]  = '{4'b1111, 1'b0, 4'b1000, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[11] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[12] = '{4'b1111, 1'b0, 4'b1000, 1'b1};
        tbl[13] = '{4'b1111, 1'b0, 4'b1000, 1'b1};
        tbl[14] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
        tbl[15] = '{4'b1111, 1'b0, 4'b1000, 1'b1};
        tbl[16] = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
        tbl[18] = '{4'b0010, 1'b1, 4'b0000, 1'b0};
        tbl[19] = '{4'b0010, 1'b0, 4'b0010, 1'b0};

        rst = 1'b0; req = 4'd0; full_force = 1'b0; rd = 1'b0; ext_wr = 1'b0;
        clr = 1'b1; sb_en = 1'b1;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        #2;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_wen", 32'(fifo_wen), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        do_reset();

        // Full rotation: four words per owner, pointer wraps 3 -> 0.
        for (int c = 0; c < 20; c++) begin
            step(4'b1111, 1'b0, 1'b0, 4'(1 << ((c / 4) % 4)), 1'((c % 4) != 0), "rot");
        end

        // Reset mid-burst with all requesting.
        step(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, "pre_rst");
        step(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, "pre_rst");
        rst = 1'b0;
        #2;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wen", 32'(fifo_wen), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_gnt_hold", 32'(gnt), 32'd0);
        rst = 1'b1;
        step(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, "post_rst");

        do_reset();
        for (int v = 0; v < 20; v++) begin
            step(tbl[v].req, tbl[v].full, 1'b0, tbl[v].gnt, tbl[v].busy, $sformatf("tbl%0d", v));
        end

        // Owner 1 stalls at burst_cnt=2 on a genuinely full FIFO.
        do_reset();
        ext_wr = 1'b1;
        repeat (510) @(posedge clk);
        #1;
        ext_wr = 1'b0;
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "fill");
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, "fill");
        chk("fifo_full_set", 32'(fifo_full), 32'd1);
        step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, "stall");
        step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, "stall");
        step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, "stall_rd");
        step(4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, "resume");
        step(4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, "resume");
        step(4'b1111, 1'b0, 1'b1, 4'b0100, 1'b0, "rotate");

`ifdef FIFO_ARB_STATS_EN
        begin
            int acc [4];
            do_reset();
            chk("stat_reset", 32'(stat_cnt[31:0]), 32'd0);
            chk("stat_reset_hi", 32'(stat_cnt[63:32]), 32'd0);
            sb_en = 1'b0;
            for (int i = 0; i < 4; i++) acc[i] = 0;
            for (int c = 0; c < 20; c++) begin
                req        = 4'($urandom_range(0, 15));
                full_force = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                for (int i = 0; i < 4; i++) if (req[i] && gnt[i]) acc[i]++;
                @(posedge clk);
                #1;
            end
            req = 4'd0; full_force = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("stat_cnt%0d", i), 32'(stat_cnt[i*16 +: 16]), 32'(acc[i]));
            end
            req = 4'b0001;
            stat_clr = 1'b1;
            @(negedge clk);
            chk("stat_clr_grant", 32'(gnt), 32'b0001);
            @(posedge clk);
            #1;
            stat_clr = 1'b0;
            req = 4'd0;
            chk("stat_clr_zero", 32'(stat_cnt[15:0]), 32'd0);
            sb_en = 1'b1;
        end
`endif

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
